// File: rtl/wb_writer_if.sv
// Bus bundle for wb_writer: producer push side, register-file write side,
// queue status and the optional bypass lookup ports.
interface wb_writer_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_reg;
  logic [DATA_W-1:0] in_data;
  logic              in_we;
  logic              wr_hold;
  logic [4:0]        w_reg;
  logic [DATA_W-1:0] w_data;
  logic              ctrl_w;
  logic [3:0]        count;
  logic              busy;
  logic [4:0]        q_reg1;
  logic [4:0]        q_reg2;
  logic              fwd_hit1;
  logic              fwd_hit2;
  logic [DATA_W-1:0] fwd_data1;
  logic [DATA_W-1:0] fwd_data2;

  modport master (
    output in_valid, in_reg, in_data, in_we, wr_hold, q_reg1, q_reg2,
    input  in_ready, w_reg, w_data, ctrl_w, count, busy,
           fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
  );

  modport slave (
    input  in_valid, in_reg, in_data, in_we, wr_hold, q_reg1, q_reg2,
    output in_ready, w_reg, w_data, ctrl_w, count, busy,
           fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
  );
endinterface

// File: rtl/wb_writer.sv
// wb_writer: small in-order write-back queue in front of a register-file
// write port. Results are queued, drained one per cycle unless wr_hold is
// high, and writes to register 0 (or entries with in_we=0) are swallowed.
// Optional feature: define WB_WRITER_BYPASS_EN to enable the combinational
// forwarding lookup (fwd_hit/fwd_data) over queued and in-flight writes.
module wb_writer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input logic        clk,
  input logic        rst,
  wb_writer_if.slave bus
);

  localparam int         PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  logic [4:0]        regMem_q  [DEPTH];
  logic [DATA_W-1:0] dataMem_q [DEPTH];
  logic [DEPTH-1:0]  weMem_q;

  logic [PTR_W-1:0]  headPtr_q, headPtr_d;
  logic [PTR_W-1:0]  tailPtr_q, tailPtr_d;
  logic [3:0]        count_q, count_d;
  logic              ctrlW_q, ctrlW_d;
  logic [4:0]        wReg_q, wReg_d;
  logic [DATA_W-1:0] wData_q, wData_d;
  logic              pushEn;
  logic              popEn;

  // Acceptance depends only on occupancy, so a full queue refuses even while draining.
  assign bus.in_ready = (count_q < DEPTH_C);
  assign bus.count    = count_q;
  assign bus.ctrl_w   = ctrlW_q;
  assign bus.w_reg    = wReg_q;
  assign bus.w_data   = wData_q;
  assign bus.busy     = (count_q != 4'd0) || ctrlW_q;

  // Next-state for pointers, occupancy and the registered write stage.
  always_comb begin
    pushEn    = bus.in_valid && (count_q < DEPTH_C);
    popEn     = (count_q != 4'd0) && !bus.wr_hold;
    headPtr_d = headPtr_q;
    tailPtr_d = tailPtr_q;
    count_d   = count_q;
    ctrlW_d   = 1'b0;
    wReg_d    = wReg_q;
    wData_d   = wData_q;

    if (pushEn) begin
      tailPtr_d = tailPtr_q + 1'b1;
    end

    if (popEn) begin
      headPtr_d = headPtr_q + 1'b1;
      ctrlW_d   = weMem_q[headPtr_q] && (regMem_q[headPtr_q] != 5'd0);
      wReg_d    = regMem_q[headPtr_q];
      wData_d   = dataMem_q[headPtr_q];
    end

    case ({pushEn, popEn})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
  end

  // Control state and output stage, cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      headPtr_q <= '0;
      tailPtr_q <= '0;
      count_q   <= 4'd0;
      ctrlW_q   <= 1'b0;
      wReg_q    <= 5'd0;
      wData_q   <= '0;
    end else begin
      headPtr_q <= headPtr_d;
      tailPtr_q <= tailPtr_d;
      count_q   <= count_d;
      ctrlW_q   <= ctrlW_d;
      wReg_q    <= wReg_d;
      wData_q   <= wData_d;
    end
  end

  // Entry storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (pushEn) begin
      regMem_q[tailPtr_q]  <= bus.in_reg;
      dataMem_q[tailPtr_q] <= bus.in_data;
      weMem_q[tailPtr_q]   <= bus.in_we;
    end
  end

`ifdef WB_WRITER_BYPASS_EN
  logic [4:0]        lookReg  [2];
  logic              lookHit  [2];
  logic [DATA_W-1:0] lookData [2];
  logic [PTR_W-1:0]  scanIdx;

  assign lookReg[0]    = bus.q_reg1;
  assign lookReg[1]    = bus.q_reg2;
  assign bus.fwd_hit1  = lookHit[0];
  assign bus.fwd_hit2  = lookHit[1];
  assign bus.fwd_data1 = lookData[0];
  assign bus.fwd_data2 = lookData[1];

  // Scan oldest to newest (output stage, then queue from head) so the newest match wins.
  always_comb begin
    scanIdx = '0;
    for (int k = 0; k < 2; k++) begin
      lookHit[k]  = 1'b0;
      lookData[k] = '0;
      if (lookReg[k] != 5'd0) begin
        if (ctrlW_q && (wReg_q == lookReg[k])) begin
          lookHit[k]  = 1'b1;
          lookData[k] = wData_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
          scanIdx = headPtr_q + PTR_W'(i);
          if ((4'(i) < count_q) && weMem_q[scanIdx] &&
              (regMem_q[scanIdx] == lookReg[k])) begin
            lookHit[k]  = 1'b1;
            lookData[k] = dataMem_q[scanIdx];
          end
        end
      end
    end
  end
`else
  logic unused_bypass;

  assign unused_bypass = ^{bus.q_reg1, bus.q_reg2};
  assign bus.fwd_hit1  = 1'b0;
  assign bus.fwd_hit2  = 1'b0;
  assign bus.fwd_data1 = '0;
  assign bus.fwd_data2 = '0;
`endif

endmodule

// File: tb/tb_wb_writer.sv
// Testbench for wb_writer: directed scenarios plus a randomized run, all
// checked against a queue-based behavioural model of the write-back queue.
module tb_wb_writer;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
    logic        we;
  } entry_t;

  logic clk = 1'b0;
  logic rst;

  int vectors     = 0;
  int miscompares = 0;

  entry_t      model[$];
  logic        mCtrl;
  logic [4:0]  mWReg;
  logic [31:0] mWData;

  wb_writer_if #(.DATA_W(DATA_W)) bus ();

  wb_writer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic modelReset();
    model.delete();
    mCtrl  = 1'b0;
    mWReg  = 5'd0;
    mWData = 32'd0;
  endtask

  // Drive one cycle of inputs, advance the model at the edge, return at the next falling edge.
  task automatic step(input logic v, input logic [4:0] r, input logic [31:0] d,
                      input logic we, input logic h);
    entry_t e;
    bit     rdy;
    bus.in_valid = v;
    bus.in_reg   = r;
    bus.in_data  = d;
    bus.in_we    = we;
    bus.wr_hold  = h;
    @(posedge clk);
    if (!rst) begin
      rdy = (model.size() < DEPTH);
      if (model.size() != 0 && !h) begin
        e      = model.pop_front();
        mCtrl  = e.we && (e.r != 5'd0);
        mWReg  = e.r;
        mWData = e.d;
      end else begin
        mCtrl = 1'b0;
      end
      if (v && rdy) model.push_back({r, d, we});
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Newest matching pending write, queue taking priority over the output stage.
  function automatic void refFwd(input logic [4:0] q, output logic hit, output logic [31:0] data);
    hit  = 1'b0;
    data = 32'd0;
    if (q != 5'd0) begin
      if (mCtrl && mWReg == q) begin hit = 1'b1; data = mWData; end
      foreach (model[i]) begin
        if (model[i].we && model[i].r == q) begin hit = 1'b1; data = model[i].d; end
      end
    end
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    modelReset();
    vectors++; if (bus.count !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_count got=%0d exp=0", bus.count); end
    vectors++; if (bus.ctrl_w !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ctrl_w got=%b exp=0", bus.ctrl_w); end
    vectors++; if (bus.w_reg !== 5'd0) begin miscompares++; $display("[TB] FAIL reset_w_reg got=%0d exp=0", bus.w_reg); end
    vectors++; if (bus.w_data !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_w_data got=%h exp=0", bus.w_data); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got=%b exp=0", bus.busy); end
    vectors++; if (bus.fwd_hit1 !== 1'b0 || bus.fwd_hit2 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_fwd_hit got=%b%b exp=00", bus.fwd_hit1, bus.fwd_hit2); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_write();
    step(1'b1, 5'd5, 32'h0000_0003, 1'b1, 1'b0);
    vectors++; if (bus.ctrl_w !== 1'b0) begin miscompares++; $display("[TB] FAIL single_early_ctrl got=%b exp=0", bus.ctrl_w); end
    vectors++; if (bus.count !== 4'd1) begin miscompares++; $display("[TB] FAIL single_count got=%0d exp=1", bus.count); end
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    vectors++; if (bus.ctrl_w !== 1'b1) begin miscompares++; $display("[TB] FAIL single_ctrl got=%b exp=1", bus.ctrl_w); end
    vectors++; if (bus.w_reg !== 5'd5) begin miscompares++; $display("[TB] FAIL single_w_reg got=%0d exp=5", bus.w_reg); end
    vectors++; if (bus.w_data !== 32'd3) begin miscompares++; $display("[TB] FAIL single_w_data got=%h exp=3", bus.w_data); end
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    vectors++; if (bus.ctrl_w !== 1'b0) begin miscompares++; $display("[TB] FAIL single_pulse_len got=%b exp=0", bus.ctrl_w); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL single_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_zero_drop();
    step(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    vectors++; if (bus.count !== 4'd1) begin miscompares++; $display("[TB] FAIL zero_count_push got=%0d exp=1", bus.count); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      vectors++; if (bus.ctrl_w !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_ctrl cycle=%0d got=%b exp=0", i, bus.ctrl_w); end
    end
    vectors++; if (bus.count !== 4'd0) begin miscompares++; $display("[TB] FAIL zero_count_end got=%0d exp=0", bus.count); end
  endtask

  task automatic test_full_hold();
    step(1'b1, 5'd1, 32'h11, 1'b1, 1'b1);
    step(1'b1, 5'd2, 32'h22, 1'b1, 1'b1);
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL full_ready got=%b exp=0", bus.in_ready); end
    vectors++; if (bus.count !== 4'd2) begin miscompares++; $display("[TB] FAIL full_count got=%0d exp=2", bus.count); end
    step(1'b1, 5'd3, 32'h33, 1'b1, 1'b1);
    vectors++; if (bus.count !== 4'd2 || bus.ctrl_w !== 1'b0) begin miscompares++; $display("[TB] FAIL full_refuse count=%0d ctrl=%b exp=2/0", bus.count, bus.ctrl_w); end
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    vectors++; if (bus.ctrl_w !== 1'b1 || bus.w_reg !== 5'd1 || bus.w_data !== 32'h11) begin miscompares++; $display("[TB] FAIL full_first ctrl=%b reg=%0d data=%h exp=1/1/11", bus.ctrl_w, bus.w_reg, bus.w_data); end
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    vectors++; if (bus.ctrl_w !== 1'b1 || bus.w_reg !== 5'd2 || bus.w_data !== 32'h22) begin miscompares++; $display("[TB] FAIL full_second ctrl=%b reg=%0d data=%h exp=1/2/22", bus.ctrl_w, bus.w_reg, bus.w_data); end
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    vectors++; if (bus.ctrl_w !== 1'b0 || bus.count !== 4'd0) begin miscompares++; $display("[TB] FAIL full_drained ctrl=%b count=%0d exp=0/0", bus.ctrl_w, bus.count); end
  endtask

  task automatic test_bypass();
    logic        on;
    logic [31:0] dB;
`ifdef WB_WRITER_BYPASS_EN
    on = 1'b1;
`else
    on = 1'b0;
`endif
    dB = on ? 32'hB : 32'h0;
    step(1'b1, 5'd7, 32'hA, 1'b1, 1'b1);
    step(1'b1, 5'd7, 32'hB, 1'b1, 1'b1);
    bus.q_reg1 = 5'd7;
    bus.q_reg2 = 5'd0;
    #1;
    vectors++; if (bus.fwd_hit1 !== on || bus.fwd_data1 !== dB) begin miscompares++; $display("[TB] FAIL bypass_queue hit=%b data=%h exp=%b/%h", bus.fwd_hit1, bus.fwd_data1, on, dB); end
    vectors++; if (bus.fwd_hit2 !== 1'b0 || bus.fwd_data2 !== 32'd0) begin miscompares++; $display("[TB] FAIL bypass_zero hit=%b data=%h exp=0/0", bus.fwd_hit2, bus.fwd_data2); end
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    vectors++; if (bus.fwd_hit1 !== on || bus.fwd_data1 !== dB) begin miscompares++; $display("[TB] FAIL bypass_newest hit=%b data=%h exp=%b/%h", bus.fwd_hit1, bus.fwd_data1, on, dB); end
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    vectors++; if (bus.fwd_hit1 !== on || bus.fwd_data1 !== dB) begin miscompares++; $display("[TB] FAIL bypass_stage hit=%b data=%h exp=%b/%h", bus.fwd_hit1, bus.fwd_data1, on, dB); end
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    vectors++; if (bus.fwd_hit1 !== 1'b0) begin miscompares++; $display("[TB] FAIL bypass_idle hit=%b exp=0", bus.fwd_hit1); end
    bus.q_reg1 = 5'd0;
  endtask

  task automatic test_async_reset();
    step(1'b1, 5'd4, 32'h44, 1'b1, 1'b1);
    step(1'b1, 5'd6, 32'h66, 1'b1, 1'b1);
    vectors++; if (bus.count !== 4'd2) begin miscompares++; $display("[TB] FAIL areset_pre_count got=%0d exp=2", bus.count); end
    #2 rst = 1'b1;
    #1;
    vectors++; if (bus.count !== 4'd0 || bus.ctrl_w !== 1'b0 || bus.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL areset_immediate count=%0d ctrl=%b ready=%b exp=0/0/1", bus.count, bus.ctrl_w, bus.in_ready); end
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      vectors++; if (bus.ctrl_w !== 1'b0 || bus.count !== 4'd0) begin miscompares++; $display("[TB] FAIL areset_after cycle=%0d ctrl=%b count=%0d exp=0/0", i, bus.ctrl_w, bus.count); end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 1; k <= 8; k++) begin
      vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL stream_ready k=%0d got=%b exp=1", k, bus.in_ready); end
      step(1'b1, 5'(k), 32'(k * 2), 1'b1, 1'b0);
      if (k == 1) begin
        vectors++; if (bus.ctrl_w !== 1'b0) begin miscompares++; $display("[TB] FAIL stream_first ctrl=%b exp=0", bus.ctrl_w); end
      end else begin
        vectors++; if (bus.ctrl_w !== 1'b1 || bus.w_reg !== 5'(k - 1) || bus.w_data !== 32'((k - 1) * 2)) begin miscompares++; $display("[TB] FAIL stream_write k=%0d ctrl=%b reg=%0d data=%h exp=1/%0d/%0h", k, bus.ctrl_w, bus.w_reg, bus.w_data, k - 1, (k - 1) * 2); end
      end
    end
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    vectors++; if (bus.ctrl_w !== 1'b1 || bus.w_reg !== 5'd8 || bus.w_data !== 32'd16) begin miscompares++; $display("[TB] FAIL stream_last ctrl=%b reg=%0d data=%h exp=1/8/10", bus.ctrl_w, bus.w_reg, bus.w_data); end
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    vectors++; if (bus.ctrl_w !== 1'b0) begin miscompares++; $display("[TB] FAIL stream_end ctrl=%b exp=0", bus.ctrl_w); end
  endtask

  task automatic test_random();
    logic        eHit1, eHit2;
    logic [31:0] eData1, eData2;
    for (int n = 0; n < 400; n++) begin
      bus.q_reg1 = 5'($urandom_range(0, 7));
      bus.q_reg2 = 5'($urandom_range(0, 7));
      #1;
`ifdef WB_WRITER_BYPASS_EN
      refFwd(bus.q_reg1, eHit1, eData1);
      refFwd(bus.q_reg2, eHit2, eData2);
`else
      eHit1 = 1'b0; eData1 = 32'd0; eHit2 = 1'b0; eData2 = 32'd0;
`endif
      vectors++; if (bus.count !== 4'(model.size())) begin miscompares++; $display("[TB] FAIL rand_count n=%0d got=%0d exp=%0d", n, bus.count, model.size()); end
      vectors++; if (bus.in_ready !== (model.size() < DEPTH)) begin miscompares++; $display("[TB] FAIL rand_ready n=%0d got=%b exp=%b", n, bus.in_ready, model.size() < DEPTH); end
      vectors++; if (bus.ctrl_w !== mCtrl) begin miscompares++; $display("[TB] FAIL rand_ctrl n=%0d got=%b exp=%b", n, bus.ctrl_w, mCtrl); end
      if (mCtrl) begin
        vectors++; if (bus.w_reg !== mWReg || bus.w_data !== mWData) begin miscompares++; $display("[TB] FAIL rand_write n=%0d reg=%0d data=%h exp=%0d/%h", n, bus.w_reg, bus.w_data, mWReg, mWData); end
      end
      vectors++; if (bus.busy !== (model.size() != 0 || mCtrl)) begin miscompares++; $display("[TB] FAIL rand_busy n=%0d got=%b", n, bus.busy); end
      vectors++; if (bus.fwd_hit1 !== eHit1 || bus.fwd_data1 !== eData1) begin miscompares++; $display("[TB] FAIL rand_fwd1 n=%0d hit=%b data=%h exp=%b/%h", n, bus.fwd_hit1, bus.fwd_data1, eHit1, eData1); end
      vectors++; if (bus.fwd_hit2 !== eHit2 || bus.fwd_data2 !== eData2) begin miscompares++; $display("[TB] FAIL rand_fwd2 n=%0d hit=%b data=%h exp=%b/%h", n, bus.fwd_hit2, bus.fwd_data2, eHit2, eData2); end
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 3) == 0));
    end
    bus.q_reg1 = 5'd0;
    bus.q_reg2 = 5'd0;
  endtask

  // Scenario sequence followed by the summary line.
  initial begin
    bus.in_valid = 1'b0;
    bus.in_reg   = 5'd0;
    bus.in_data  = 32'd0;
    bus.in_we    = 1'b0;
    bus.wr_hold  = 1'b0;
    bus.q_reg1   = 5'd0;
    bus.q_reg2   = 5'd0;
    rst          = 1'b1;
    modelReset();
    test_reset();
    test_single_write();
    test_zero_drop();
    test_full_hold();
    test_bypass();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_writer.md
WB_WRITER -- requirements
Module: wb_writer

Interface
REQ-001 Parameter DATA_W, default 32: width of the write data path.
REQ-002 Parameter DEPTH, default 2: pending-write queue entries, power of two, 2..8.
REQ-003 clk  input  1  system clock; all state is updated on the rising edge.
REQ-004 rst  input  1  reset; one clock, reset asynchronous and active-high.
REQ-005 in_valid  input  1  producer offers a result this cycle.
REQ-006 in_ready  output  1  queue can accept; high when count < DEPTH.
REQ-007 in_reg  input  5  destination register number.
REQ-008 in_data  input  DATA_W  result value.
REQ-009 in_we  input  1  0 = entry consumes a slot but produces no register write.
REQ-010 wr_hold  input  1  register-file write port unavailable; draining is suspended.
REQ-011 w_reg  output  5  register-file write address, registered.
REQ-012 w_data  output  DATA_W  register-file write data, registered.
REQ-013 ctrl_w  output  1  register-file write strobe, registered, one cycle per write.
REQ-014 count  output  4  number of queued entries, 0..DEPTH.
REQ-015 busy  output  1  count != 0 or ctrl_w high.
REQ-016 q_reg1, q_reg2  input  5 each  bypass lookup addresses (BYPASS_EN only).
REQ-017 fwd_hit1/2  output  1 each; fwd_data1/2  output  DATA_W each  bypass results (BYPASS_EN only).

Function
REQ-018 Push: in_valid and in_ready at a rising edge stores {in_reg, in_data, in_we} at the tail.
REQ-019 in_ready SHALL depend only on count, never on the same-cycle pop; a full queue refuses even while draining.
REQ-020 Pop: at each rising edge with count != 0 and wr_hold low, the head SHALL be removed and loaded into the output stage.
REQ-021 Output stage: ctrl_w SHALL be 1 for exactly the cycle after a pop whose entry has in_we=1 and in_reg != 0; otherwise 0.
REQ-022 w_reg/w_data SHALL hold the last popped entry's values; they are don't-care and unchanged when ctrl_w is 0.
REQ-023 Writes to register 0 SHALL be dropped: the entry is popped with ctrl_w held low.
REQ-024 Latency: an entry pushed at edge N into an empty queue with wr_hold low SHALL show ctrl_w high in the cycle after edge N+1.
REQ-025 Throughput: one pop per cycle sustained; a simultaneous push and pop leaves count unchanged.
REQ-026 Order: entries are written in acceptance order; head/tail pointers wrap modulo DEPTH.
REQ-027 wr_hold high SHALL force ctrl_w to 0 in the following cycle and freeze the queue head; pushes still proceed if count < DEPTH.
REQ-028 A push with in_valid high and in_ready low SHALL be ignored with no state change.

Reset
REQ-029 rst high SHALL immediately clear count, pointers, ctrl_w, w_reg, w_data, and fwd_hit1/2 to 0, with in_ready at 1.
REQ-030 Reset mid-operation SHALL discard all queued entries; no ctrl_w pulse follows deassertion until a new push.

Configuration
REQ-031 Macro WB_WRITER_BYPASS_EN defined: fwd_hitK SHALL be high combinationally when q_regK != 0 matches a queued entry with in_we=1, or the output stage with ctrl_w high.
REQ-032 With the macro defined, the newest matching entry SHALL supply fwd_dataK (tail-most queue entry over the output stage).
REQ-033 Macro undefined: q_reg1/2 SHALL be ignored, fwd_hit1/2 tied to 0, and fwd_data1/2 tied to 0.

Verification
REQ-034 Single write: push reg 5 = 0x0000_0003, wr_hold 0 -> one-cycle ctrl_w, w_reg=5, w_data=3, two edges after the push.
REQ-035 Zero drop: push reg 0 = 0xFFFF_FFFF -> count returns to 0, ctrl_w never high.
REQ-036 Full/hold: wr_hold=1, push regs 1,2,3 with data 0x11,0x22,0x33 -> third push refused (in_ready 0, count 2); release hold -> writes 1 then 2, each ctrl_w one cycle apart.
REQ-037 Bypass (macro defined): wr_hold=1, push reg 7 = 0xA, then reg 7 = 0xB; q_reg1=7 -> fwd_hit1=1, fwd_data1=0xB; q_reg2=0 -> fwd_hit2=0.
REQ-038 Async reset: assert rst mid-cycle with count 2 -> count 0, ctrl_w 0 before the next edge; no write after release.
REQ-039 Streaming: push 8 back-to-back entries (regs 1..8, data = reg number x 2) with wr_hold 0 -> 8 consecutive ctrl_w cycles in order, in_ready never low.
